// File: rtl/main_fsm.sv
// ---------------------------------------------------------------------------
// main_fsm -- multicycle processor main control state machine
//
// Sequences every instruction through FETCH / DECODE and then the memory,
// data-processing or branch path. It drives datapath selects and raw write
// enables. Condition gating of RegW / MemW / Branch happens outside this block.
//
// Ports
//   clk        : sole clock, rising edge
//   reset      : asynchronous active-high reset (forces FETCH)
//   Op[1:0]    : instruction class 00 DP, 01 memory, 10 branch, 11 undefined
//   Funct[5:0] : Funct[5] immediate flag, Funct[0] load/store (S/L) bit
//   MemReady   : shared memory completes the current access this cycle
//   IRWrite    : instruction register load enable
//   NextPC     : PC update request
//   AdrSrc     : memory address select (0 PC, 1 ALU result)
//   ALUSrcA/B  : ALU operand selects
//   ResultSrc  : result mux select (00 ALUOut, 01 read data, 10 ALU result)
//   RegW/MemW/Branch/ALUOp : raw enables, before condition gating
//   State[3:0] : current state encoding, for debug
// ---------------------------------------------------------------------------
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t     r_state;
  state_t     w_next;

  logic       w_irwrite;
  logic       w_nextpc;
  logic       w_regw;
  logic       w_memw;
  logic       w_branch;

  // Only the immediate flag and the S/L bit steer this FSM.
  logic       w_unused_funct;
  assign w_unused_funct = ^Funct[4:1];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          2'b00:   w_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      default:    w_next = S_FETCH;
    endcase
  end

  // Output decode: Moore except for the MemReady-qualified fetch enables
  always_comb begin
    w_irwrite = 1'b0;
    w_nextpc  = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    w_regw    = 1'b0;
    w_memw    = 1'b0;
    w_branch  = 1'b0;
    ALUOp     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_irwrite = MemReady;
        w_nextpc  = MemReady;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcB   = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc    = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        w_regw    = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        w_memw    = 1'b1;
      end
      S_EXECUTER: begin
        ALUOp     = 1'b1;
      end
      S_EXECUTEI: begin
        ALUSrcB   = 2'b01;
        ALUOp     = 1'b1;
      end
      S_ALUWB: begin
        w_regw    = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        w_branch  = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset masks every enable combinationally, so a write in flight is
  // dropped immediately rather than at the next edge.
  assign IRWrite = w_irwrite & ~reset;
  assign NextPC  = w_nextpc  & ~reset;
  assign RegW    = w_regw    & ~reset;
  assign MemW    = w_memw    & ~reset;
  assign Branch  = w_branch  & ~reset;
  assign State   = r_state;

endmodule

// File: tb/tb_main_fsm.sv
module tb_main_fsm;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;
  logic       IRWrite, NextPC, AdrSrc, RegW, MemW, Branch, ALUOp;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0] State;

  main_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .RegW(RegW), .MemW(MemW), .Branch(Branch), .ALUOp(ALUOp),
    .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {State, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, RegW, MemW, Branch, ALUOp}
  logic [16:0] q_exp[$];
  string       q_nm[$];
  int          vectors     = 0;
  int          miscompares = 0;
  event        async_ev;

  // Expected outputs for a state, taken from the per-state output table.
  function automatic logic [16:0] exp_vec(input logic [3:0] st, input logic mr, input logic rst);
    logic ir, npc, adr, rw, mw, br, aop;
    logic [1:0] sa, sb, rs;
    ir = 0; npc = 0; adr = 0; rw = 0; mw = 0; br = 0; aop = 0;
    sa = 2'b00; sb = 2'b00; rs = 2'b00;
    case (st)
      4'd0: begin ir = mr; npc = mr; sa = 2'b01; sb = 2'b10; rs = 2'b10; end
      4'd1: begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
      4'd2: begin sb = 2'b01; end
      4'd3: begin adr = 1; end
      4'd4: begin rs = 2'b01; rw = 1; end
      4'd5: begin adr = 1; mw = 1; end
      4'd6: begin aop = 1; end
      4'd7: begin sb = 2'b01; aop = 1; end
      4'd8: begin rw = 1; end
      4'd9: begin sb = 2'b01; rs = 2'b10; br = 1; end
      default: ;
    endcase
    if (rst) begin ir = 0; npc = 0; rw = 0; mw = 0; br = 0; end
    return {st, ir, npc, adr, sa, sb, rs, rw, mw, br, aop};
  endfunction

  // Monitor: compares the DUT outputs against the oldest expected entry.
  always begin
    logic [16:0] e, g;
    string n;
    @(negedge clk or async_ev);
    if (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      n = q_nm.pop_front();
      g = {State, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, RegW, MemW, Branch, ALUOp};
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL %s: got %05h (state %0d) required %05h (state %0d)", n, g, g[16:13], e, e[16:13]);
      end
    end
  end

  // One clock cycle of stimulus plus its expected response.
  task automatic cyc(input logic [1:0] op, input logic [5:0] fn, input logic mr,
                     input logic rst, input logic [3:0] st, input string nm);
    @(posedge clk);
    #1;
    reset = rst; Op = op; Funct = fn; MemReady = mr;
    q_exp.push_back(exp_vec(st, mr, rst));
    q_nm.push_back(nm);
  endtask

  initial begin
    reset = 1'b1; Op = 2'b00; Funct = 6'd0; MemReady = 1'b1;

    cyc(2'b00, 6'b000000, 1, 1, 4'd0, "rst_hold_mr1");
    cyc(2'b00, 6'b000000, 0, 1, 4'd0, "rst_hold_mr0");

    // ADD register: 0,1,6,8
    cyc(2'b00, 6'b000100, 1, 0, 4'd0, "add_fetch");
    cyc(2'b00, 6'b000100, 1, 0, 4'd1, "add_decode");
    cyc(2'b00, 6'b000100, 1, 0, 4'd6, "add_executer");
    cyc(2'b00, 6'b000100, 1, 0, 4'd8, "add_aluwb");

    // LDR with two wait states: 0,1,2,3,3,3,4
    cyc(2'b01, 6'b011001, 1, 0, 4'd0, "ldr_fetch");
    cyc(2'b01, 6'b011001, 1, 0, 4'd1, "ldr_decode");
    cyc(2'b01, 6'b011001, 1, 0, 4'd2, "ldr_memadr");
    cyc(2'b01, 6'b011001, 0, 0, 4'd3, "ldr_memread_w1");
    cyc(2'b01, 6'b011001, 0, 0, 4'd3, "ldr_memread_w2");
    cyc(2'b01, 6'b011001, 1, 0, 4'd3, "ldr_memread_done");
    cyc(2'b01, 6'b011001, 1, 0, 4'd4, "ldr_memwb");

    // STR with one wait state: MemW for two cycles
    cyc(2'b01, 6'b011000, 1, 0, 4'd0, "str_fetch");
    cyc(2'b01, 6'b011000, 1, 0, 4'd1, "str_decode");
    cyc(2'b01, 6'b011000, 1, 0, 4'd2, "str_memadr");
    cyc(2'b01, 6'b011000, 0, 0, 4'd5, "str_memwrite_w1");
    cyc(2'b01, 6'b011000, 1, 0, 4'd5, "str_memwrite_done");

    // Branch: 0,1,9
    cyc(2'b10, 6'b000000, 1, 0, 4'd0, "b_fetch");
    cyc(2'b10, 6'b000000, 1, 0, 4'd1, "b_decode");
    cyc(2'b10, 6'b000000, 1, 0, 4'd9, "b_branch");

    // FETCH stalled three cycles, then undefined Op returns to FETCH
    cyc(2'b11, 6'b000000, 0, 0, 4'd0, "fetch_wait1");
    cyc(2'b11, 6'b000000, 0, 0, 4'd0, "fetch_wait2");
    cyc(2'b11, 6'b000000, 0, 0, 4'd0, "fetch_wait3");
    cyc(2'b11, 6'b000000, 1, 0, 4'd0, "fetch_ready");
    cyc(2'b11, 6'b000000, 1, 0, 4'd1, "undef_decode");

    // ADD immediate: 0,1,7,8
    cyc(2'b00, 6'b100100, 1, 0, 4'd0, "addi_fetch");
    cyc(2'b00, 6'b100100, 1, 0, 4'd1, "addi_decode");
    cyc(2'b00, 6'b100100, 1, 0, 4'd7, "addi_executei");
    cyc(2'b00, 6'b100100, 1, 0, 4'd8, "addi_aluwb");

    // STR interrupted by asynchronous reset during the MEMWRITE wait
    cyc(2'b01, 6'b011000, 1, 0, 4'd0, "rstw_fetch");
    cyc(2'b01, 6'b011000, 1, 0, 4'd1, "rstw_decode");
    cyc(2'b01, 6'b011000, 1, 0, 4'd2, "rstw_memadr");
    cyc(2'b01, 6'b011000, 0, 0, 4'd5, "rstw_memwrite");
    #6;
    reset = 1'b1; MemReady = 1'b1;
    q_exp.push_back(exp_vec(4'd0, 1'b1, 1'b1));
    q_nm.push_back("async_reset_midcycle");
    #1;
    ->async_ev;
    cyc(2'b10, 6'b000000, 1, 1, 4'd0, "rst_held_edge");

    // Release: first edge evaluates FETCH normally
    cyc(2'b10, 6'b000000, 1, 0, 4'd0, "post_rst_fetch");
    cyc(2'b10, 6'b000000, 1, 0, 4'd1, "post_rst_decode");
    cyc(2'b10, 6'b000000, 1, 0, 4'd9, "post_rst_branch");
    cyc(2'b00, 6'b000000, 0, 0, 4'd0, "final_fetch");

    repeat (3) @(negedge clk);
    #1;
    if (q_exp.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending entries required 0", q_exp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 The block SHALL provide port clk, input, 1 bit, sole clock; all state updates occur on its rising edge.
REQ-002 The block SHALL provide port reset, input, 1 bit, asynchronous active-high reset.
REQ-003 The block SHALL provide port Op, input, 2 bits, instruction class Instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined.
REQ-004 The block SHALL provide port Funct, input, 6 bits, Instr[25:20]; Funct[5] is the immediate flag, Funct[0] is S/L.
REQ-005 The block SHALL provide port MemReady, input, 1 bit, shared memory completes the current access this cycle.
REQ-006 The block SHALL provide port IRWrite, output, 1 bit, instruction register load enable.
REQ-007 The block SHALL provide port NextPC, output, 1 bit, PC update request.
REQ-008 The block SHALL provide port AdrSrc, output, 1 bit, memory address select: 0 PC, 1 ALU result.
REQ-009 The block SHALL provide ports ALUSrcA and ALUSrcB, outputs, 2 bits each, ALU operand selects.
REQ-010 The block SHALL provide port ResultSrc, output, 2 bits, result mux select: 00 ALUOut, 01 read data, 10 ALU result.
REQ-011 The block SHALL provide ports RegW, MemW, Branch and ALUOp, outputs, 1 bit each, raw register-write, memory-write, branch and ALU-decode enables, all before condition gating.
REQ-012 The block SHALL provide port State, output, 4 bits, current state encoding for debug.

Function
REQ-013 States and encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9.
REQ-014 FETCH SHALL drive AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUOp=0 and ResultSrc=10, and SHALL assert IRWrite=NextPC=MemReady; it stays in FETCH while MemReady=0 and goes to DECODE when MemReady=1.
REQ-015 DECODE SHALL drive ALUSrcA=01, ALUSrcB=10 and ResultSrc=10, then go to MEMADR if Op=01, EXECUTER if Op=00 and Funct[5]=0, EXECUTEI if Op=00 and Funct[5]=1, BRANCH if Op=10, and FETCH if Op=11.
REQ-016 MEMADR SHALL drive ALUSrcA=00, ALUSrcB=01 and ALUOp=0, then go to MEMREAD if Funct[0]=1, else MEMWRITE.
REQ-017 MEMREAD SHALL drive AdrSrc=1 and ResultSrc=00, holding until MemReady=1, then go to MEMWB.
REQ-018 MEMWB SHALL drive ResultSrc=01 and RegW=1 for exactly one cycle, then go to FETCH.
REQ-019 MEMWRITE SHALL drive AdrSrc=1, ResultSrc=00 and MemW=1 on every cycle until MemReady=1, then go to FETCH.
REQ-020 EXECUTER SHALL drive ALUSrcA=00, ALUSrcB=00 and ALUOp=1; EXECUTEI SHALL drive ALUSrcA=00, ALUSrcB=01 and ALUOp=1; both go to ALUWB.
REQ-021 ALUWB SHALL drive ResultSrc=00 and RegW=1 for one cycle, then go to FETCH.
REQ-022 BRANCH SHALL drive ALUSrcA=00, ALUSrcB=01, ResultSrc=10 and Branch=1 for one cycle, then go to FETCH.
REQ-023 Any output not listed for a state SHALL be 0.
REQ-024 Outputs SHALL depend on current state only, except that IRWrite and NextPC are also gated by MemReady in FETCH.
REQ-025 An unused state encoding (10-15) SHALL go to FETCH on the next edge with all enables at 0.
REQ-026 Minimum instruction latency SHALL be: branch 3 cycles, data-processing 4, store 4, load 5, each with zero wait states; every MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.

Reset
REQ-027 Asserting reset SHALL force State=FETCH immediately, independent of clk, and hold it while asserted.
REQ-028 While reset is high, IRWrite, NextPC, RegW, MemW and Branch SHALL be 0, regardless of MemReady.
REQ-029 Reset during any state, including a MEMWRITE wait, SHALL drop MemW combinationally, with no write completed.
REQ-030 After reset deasserts, the first rising edge SHALL evaluate FETCH transitions normally.

Verification
REQ-031 Reset, then MemReady=1 with an ADD reg instruction (Op=00, Funct=000100) -> states 0,1,6,8,0; RegW=1 only in state 8; IRWrite=1 only in the first cycle.
REQ-032 LDR (Op=01, Funct=011001) with MemReady low for 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0; AdrSrc=1 during state 3.
REQ-033 STR (Op=01, Funct=011000) with MemReady low for 1 cycle in MEMWRITE -> MemW=1 for 2 consecutive cycles, then FETCH; RegW never 1.
REQ-034 B (Op=10) -> states 0,1,9,0; Branch=1 for exactly one cycle.
REQ-035 FETCH with MemReady=0 for 3 cycles -> state holds 0 and IRWrite/NextPC stay 0, then assert for one cycle when MemReady=1.
REQ-036 Assert reset asynchronously mid-MEMWRITE -> State=0 and MemW=0 before the next clk edge; Op=11 in DECODE -> FETCH with no enables.
